// File: rtl/compute_dispatcher.sv
// compute_dispatcher: accepts one request at a time, launches the selected
// compute unit, and returns either the unit's result or TIMEOUT_WORD if the
// unit does not answer within TIMEOUT_CYCLES wait cycles.
module compute_dispatcher #(
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  parameter logic [127:0] TIMEOUT_WORD   = {128{1'b1}}
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] rx_data,
  input  logic [1:0]   op_code,
  input  logic         rx_irq,
  output logic [63:0]  param1,
  output logic [63:0]  param2,
  output logic [3:0]   unit_start,
  input  logic [3:0]   unit_done,
  input  logic [511:0] unit_result,
  output logic [127:0] tx_data,
  output logic         tx_wr,
  output logic         busy,
  output logic         timeout,
  output logic [7:0]   drop_count
);

  localparam int NUM_UNITS = 4;
  localparam int TIMER_W   = 16;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_e;

  // Per-unit view of the flat result bus
  logic [NUM_UNITS-1:0][127:0] result_w;
  assign result_w = unit_result;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [63:0]          param1_q, param1_d;
  logic [63:0]          param2_q, param2_d;
  logic [3:0]           start_q, start_d;
  logic [127:0]         tx_data_q, tx_data_d;
  logic                 tx_wr_q, tx_wr_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [7:0]           drop_q, drop_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 done_hit;

  // Only the launched unit's done bit matters; the others are ignored
  assign done_hit = unit_done[op_q];

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    param1_d  = param1_q;
    param2_d  = param2_q;
    start_d   = 4'b0000;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    timeout_d = timeout_q;
    drop_d    = drop_q;
    timer_d   = timer_q;

    case (state_q)
      S_IDLE: begin
        if (rx_irq) begin
          param1_d = rx_data[127:64];
          param2_d = rx_data[63:0];
          op_d     = op_code;
          start_d  = 4'b0001 << op_code;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = TIMER_LOAD;
        if (done_hit) begin
          tx_data_d = result_w[op_q];
          tx_wr_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = S_RESPOND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion wins over expiry on the same cycle
        if (done_hit) begin
          tx_data_d = result_w[op_q];
          tx_wr_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = S_RESPOND;
        end else if (timer_q == '0) begin
          tx_data_d = TIMEOUT_WORD;
          tx_wr_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RESPOND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_RESPOND: begin
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Requests arriving while busy are discarded and counted
    if (rx_irq && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      param1_q  <= '0;
      param2_q  <= '0;
      start_q   <= 4'b0000;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 8'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      param1_q  <= param1_d;
      param2_q  <= param2_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
      timer_q   <= timer_d;
    end
  end

  assign param1     = param1_q;
  assign param2     = param2_q;
  assign unit_start = start_q;
  assign tx_data    = tx_data_q;
  assign tx_wr      = tx_wr_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_compute_dispatcher.sv
// tb_compute_dispatcher: randomized requests with a behavioural unit model;
// expected start pulses and responses go into queues checked by a monitor.
module tb_compute_dispatcher;

  localparam int           TO = 400;
  localparam logic [127:0] TW = {128{1'b1}};

  logic         clock;
  logic         reset;
  logic [127:0] rx_data;
  logic [1:0]   op_code;
  logic         rx_irq;
  logic [63:0]  param1, param2;
  logic [3:0]   unit_start;
  logic [3:0]   unit_done;
  logic [511:0] unit_result;
  logic [127:0] tx_data;
  logic         tx_wr, busy, timeout;
  logic [7:0]   drop_count;

  compute_dispatcher #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WORD(TW)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .op_code(op_code),
    .rx_irq(rx_irq), .param1(param1), .param2(param2), .unit_start(unit_start),
    .unit_done(unit_done), .unit_result(unit_result), .tx_data(tx_data),
    .tx_wr(tx_wr), .busy(busy), .timeout(timeout), .drop_count(drop_count)
  );

  typedef struct { logic [3:0] oh; logic [63:0] p1; logic [63:0] p2; int cyc; } start_t;
  typedef struct { logic [127:0] data; logic to; int cyc; } tx_t;

  start_t start_q[$];
  tx_t    tx_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     drop_model = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // What an ideal unit would return for each operation
  function automatic logic [127:0] unit_fn(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'd0:    return {64'd0, a + b};
      2'd1:    return {64'd0, a - b};
      2'd2:    return {64'd0, a} * {64'd0, b};
      default: return {a, b};
    endcase
  endfunction

  // Monitor: every start pulse and every response must match the queue head
  always @(negedge clock) begin
    start_t se;
    tx_t    te;
    if (reset) begin
      if (unit_start != 4'b0000) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got %b expected none (cycle %0d)", unit_start, cyc);
        end else begin
          se = start_q.pop_front();
          chk("start_onehot", unit_start, se.oh);
          chk("start_param1", param1, se.p1);
          chk("start_param2", param2, se.p2);
          chk("start_cycle", cyc, se.cyc);
        end
      end
      if (tx_wr) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_wr: got data %0h expected no response (cycle %0d)", tx_data, cyc);
        end else begin
          te = tx_q.pop_front();
          chk("tx_data", tx_data, te.data);
          chk("tx_timeout", timeout, te.to);
          chk("tx_cycle", cyc, te.cyc);
        end
      end else begin
        chk("timeout_without_tx_wr", timeout, 0);
      end
    end
  end

  task automatic rand_result_bus();
    for (int w = 0; w < 16; w++) unit_result[w*32 +: 32] = $urandom;
  endtask

  // One request. Called at a negedge with the DUT idle. d = cycles from the
  // start pulse to the done pulse; the window accepts d in 0..TO.
  // noise: 0 none, 1 random other-unit dones, 2 unit 1 done with result 7.
  // drops: 0 none, 1 random extra rx_irq, 2 rx_irq every busy cycle.
  task automatic run_txn(input logic [1:0] op, input logic [63:0] p1, input logic [63:0] p2,
                         input int d, input int noise, input int drops);
    logic [127:0] res;
    logic [127:0] exp_data;
    logic [3:0]   oh, mask;
    int           s, tx_cyc;
    bit           irq;
    res      = unit_fn(op, p1, p2);
    oh       = 4'b0001 << op;
    exp_data = (d <= TO) ? res : TW;
    chk("busy_before_req", busy, 0);
    rx_irq  = 1'b1;
    rx_data = {p1, p2};
    op_code = op;
    s       = cyc + 1;
    tx_cyc  = s + ((d <= TO) ? d : TO) + 1;
    start_q.push_back('{oh, p1, p2, s});
    tx_q.push_back('{exp_data, (d > TO), tx_cyc});
    for (int c = s; c <= tx_cyc; c++) begin
      @(negedge clock);
      chk("busy_during_req", busy, 1);
      irq = (drops == 2) || (drops == 1 && $urandom_range(0, 3) == 0);
      rx_irq  = irq;
      rx_data = {$urandom, $urandom, $urandom, $urandom};
      op_code = 2'($urandom_range(0, 3));
      if (irq && drop_model < 255) drop_model++;
      rand_result_bus();
      unit_done = 4'b0000;
      if (noise == 1) begin
        mask = 4'($urandom_range(0, 15));
        unit_done = mask & ~oh;
      end else if (noise == 2) begin
        unit_done[1] = 1'b1;
        unit_result[128 +: 128] = 128'd7;
      end
      if (c == s + d) begin
        unit_done[op] = 1'b1;
        unit_result[int'(op)*128 +: 128] = res;
      end
    end
    @(negedge clock);
    rx_irq    = 1'b0;
    unit_done = 4'b0000;
    chk("hold_param1", param1, p1);
    chk("hold_param2", param2, p2);
    chk("hold_tx_data", tx_data, exp_data);
    chk("drop_count", drop_count, drop_model);
    chk("busy_after_req", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_param1"}, param1, 0);
    chk({tag, "_param2"}, param2, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_unit_start"}, unit_start, 0);
    chk({tag, "_tx_wr"}, tx_wr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, r;
    reset = 1'b0; rx_irq = 1'b0; rx_data = '0; op_code = 2'd0;
    unit_done = 4'b0000; unit_result = '0;
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // Multiply path: 3*5 answered 10 cycles after start
    run_txn(2'd2, 64'd3, 64'd5, 10, 0, 0);
    // No answer in the window: timeout word; late done lands in RESPOND
    run_txn(2'd3, {$urandom, $urandom}, {$urandom, $urandom}, TO + 1, 0, 0);
    // Unit 1 keeps signalling done with 7 while unit 0 is the target (4+5=9)
    run_txn(2'd0, 64'd4, 64'd5, 12, 2, 0);
    // Done on the expiry cycle, one before it, and in the launch cycle
    run_txn(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, TO, 1, 0);
    run_txn(2'd2, {$urandom, $urandom}, {$urandom, $urandom}, TO - 1, 1, 0);
    run_txn(2'd3, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 0);
    // Request hammering while busy saturates the drop counter
    run_txn(2'd2, {$urandom, $urandom}, {$urandom, $urandom}, 350, 0, 2);
    // Back-to-back requests with no idle gap
    run_txn(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 3, 0, 0);
    run_txn(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) d = TO - 1 + $urandom_range(0, 2);
      else        d = $urandom_range(0, 25);
      run_txn(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              d, $urandom_range(0, 1), $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // Reset while waiting: request is abandoned, later done is ignored
    rx_irq = 1'b1; rx_data = {64'd11, 64'd22}; op_code = 2'd1;
    s = cyc + 1;
    start_q.push_back('{4'b0010, 64'd11, 64'd22, s});
    @(negedge clock);
    rx_irq = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    drop_model = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      unit_done = 4'b0010;
      unit_result[128 +: 128] = 128'd33;
      @(negedge clock);
    end
    unit_done = 4'b0000;
    @(negedge clock);
    chk_reset_outputs("after_late_done");

    // First request after reset release is accepted
    run_txn(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 5, 1, 1);

    repeat (3) @(negedge clock);
    chk("pending_starts", start_q.size(), 0);
    chk("pending_responses", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compute_dispatcher.md
COMPUTE_DISPATCHER -- requirements
Module: compute_dispatcher

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum number of WAIT cycles before a request is abandoned (range 2..65535).
REQ-002 Parameter: TIMEOUT_WORD, default 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, value placed on tx_data when a request times out.
REQ-003 Port: clock, input, 1, single system clock; all state changes on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous, active-low reset.
REQ-005 Port: rx_data, input, 128, request payload; [127:64] is param1, [63:0] is param2.
REQ-006 Port: op_code, input, 2, unit select sampled with rx_data: 0 add, 1 sub, 2 mult, 3 echo.
REQ-007 Port: rx_irq, input, 1, one-cycle request strobe.
REQ-008 Port: param1, output, 64, registered operand A broadcast to all units.
REQ-009 Port: param2, output, 64, registered operand B broadcast to all units.
REQ-010 Port: unit_start, output, 4, one-hot start pulse, bit n for unit n.
REQ-011 Port: unit_done, input, 4, per-unit completion pulse.
REQ-012 Port: unit_result, input, 512, unit n result on bits [128n+127:128n].
REQ-013 Port: tx_data, output, 128, registered response word.
REQ-014 Port: tx_wr, output, 1, one-cycle strobe qualifying tx_data.
REQ-015 Port: busy, output, 1, high in every state except IDLE.
REQ-016 Port: timeout, output, 1, one-cycle pulse coincident with tx_wr when the response is TIMEOUT_WORD.
REQ-017 Port: drop_count, output, 8, saturating count of rejected requests.

Function
REQ-018 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, RESPOND.
REQ-019 In IDLE, rx_irq=1 SHALL latch param1/param2 from rx_data, latch op_code into an internal op register, and move to LAUNCH on the same edge.
REQ-020 In LAUNCH, unit_start[op] SHALL be 1 for exactly one cycle with all other bits 0, and the timer SHALL load TIMEOUT_CYCLES-1; next state is WAIT.
REQ-021 In LAUNCH or WAIT, unit_done[op]=1 SHALL capture unit_result[op] into tx_data and move to RESPOND.
REQ-022 unit_done bits other than op SHALL be ignored in all states.
REQ-023 In WAIT without unit_done[op]: if timer==0, tx_data SHALL load TIMEOUT_WORD, a timeout flag SHALL be set, and the next state is RESPOND; otherwise the timer decrements.
REQ-024 unit_done[op] and timer expiry on the same cycle SHALL resolve as completion (REQ-021); no timeout.
REQ-025 In RESPOND, tx_wr SHALL be 1 for one cycle (timeout=1 if flagged); next state is IDLE, flag cleared.
REQ-026 Latency: rx_irq at edge N gives unit_start during cycle N+1; done sampled at edge M gives tx_wr during cycle M+1.
REQ-027 rx_irq in any state other than IDLE SHALL be dropped (params/op unchanged) and drop_count SHALL increment, saturating at 255.
REQ-028 param1/param2/tx_data SHALL hold their values until the next capture.
REQ-029 Back-to-back: rx_irq in the cycle immediately after RESPOND (state IDLE) SHALL be accepted normally.

Reset
REQ-030 Asserting reset (low) SHALL immediately force IDLE, with param1, param2, and tx_data set to 0; unit_start set to 4'b0000; tx_wr, busy, and timeout set to 0; drop_count and timer set to 0.
REQ-031 Reset mid-operation SHALL abandon the request with no tx_wr; late unit_done after release SHALL be ignored (IDLE).
REQ-032 Deassertion SHALL be honored on the next rising clock; first accepted rx_irq is the first one sampled in IDLE after deassertion.

Verification
REQ-033 Mult path: rx_irq with rx_data={64'd3,64'd5} and op=2, unit_done[2] 10 cycles after start with result 128'd15 -> unit_start=4'b0100 for 1 cycle, tx_data=128'd15, tx_wr for 1 cycle, timeout=0.
REQ-034 Timeout: TIMEOUT_CYCLES=4, op=3, no done -> tx_wr 5 cycles after LAUNCH with tx_data=TIMEOUT_WORD and timeout=1.
REQ-035 Wrong-unit done: op=0 while unit_done[1] pulses with result 7 -> no response; later unit_done[0] with result 9 -> tx_data=9.
REQ-036 Drop: 300 rx_irq pulses while in WAIT -> drop_count=255; params still hold the first request.
REQ-037 Done/timeout collision: unit_done[op] on the expiry cycle -> tx_data=unit result, timeout=0.
REQ-038 Reset in WAIT, then unit_done[op] after release -> no tx_wr, busy=0, all outputs at reset values.
